digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_ctrl_if.sv | 22 ++
 rtl/digit_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/digit_scan_ctrl_if.sv
// Bundle for digit_scan_ctrl: scan controls, masks, the decoder-facing outputs
// and a debug view of the scan FSM state.
// master = the block that drives run/masks, slave = digit_scan_ctrl itself.
interface digit_scan_ctrl_if;
  logic       run;
  logic [7:0] blank_mask;
  logic [7:0] blink_mask;
  logic [2:0] sel;
  logic       dec_en;
  logic       frame_done;
  logic [1:0] state_dbg;

  modport master (
    output run, blank_mask, blink_mask,
    input  sel, dec_en, frame_done, state_dbg
  );

  modport slave (
    input  run, blank_mask, blink_mask,
    output sel, dec_en, frame_done, state_dbg
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scan of eight digits through a 3-to-8
// decoder. Each digit is lit for DWELL cycles, followed by GUARD dark cycles
// during which sel moves on, so the decoder never lights a stale digit.
// Optional blink feature guarded by macro DIGIT_SCAN_BLINK_EN: a frame counter
// toggles a blink phase every BLINK_FRAMES frames, and in phase 1 digits with
// blink_mask set stay dark.
// There is no valid/ready handshake: run is a level enable sampled on every
// rising clk edge, the masks are sampled every cycle, and all outputs are
// registered.
module digit_scan_ctrl #(
  parameter int DWELL        = 16,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input logic              clk,
  input logic              reset,
  digit_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] sel;
  logic       dec_en;
  logic       frame_done;

  logic [2:0] sel_inc;
  logic [2:0] sel_nxt;
  logic       dwell_end;
  logic       guard_end;
  logic       advance;
  logic       wrap;
  logic       suppress_nxt;

  assign bus.sel        = sel;
  assign bus.dec_en     = dec_en;
  assign bus.frame_done = frame_done;
  assign bus.state_dbg  = state;

  // Decode end-of-interval, digit advance and frame wrap for the current cycle.
  always_comb begin
    sel_inc   = sel + 3'd1;
    dwell_end = (state == ST_DWELL) && (cnt == 8'(DWELL - 1));
    guard_end = (state == ST_GUARD) && (cnt == 8'(GUARD - 1));
    advance   = (dwell_end && (GUARD == 0)) || guard_end;
    wrap      = advance && (sel == 3'd7);
    sel_nxt   = advance ? sel_inc : sel;
  end

`ifdef DIGIT_SCAN_BLINK_EN
  logic [7:0] frame_cnt;
  logic       blink_ph;
  logic       blink_ph_nxt;

  // Phase flips on the wrap that completes BLINK_FRAMES frames, so the new
  // phase already applies to the first digit of the following frame.
  always_comb begin
    blink_ph_nxt = blink_ph;
    if (wrap && (frame_cnt == 8'(BLINK_FRAMES - 1))) blink_ph_nxt = ~blink_ph;
  end

  // Frame counter and blink phase; cleared whenever scanning stops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      blink_ph  <= 1'b0;
    end else if (!bus.run) begin
      frame_cnt <= 8'd0;
      blink_ph  <= 1'b0;
    end else if (wrap) begin
      frame_cnt <= (frame_cnt == 8'(BLINK_FRAMES - 1)) ? 8'd0 : frame_cnt + 8'd1;
      blink_ph  <= blink_ph_nxt;
    end
  end

  assign suppress_nxt = bus.blank_mask[sel_nxt] |
                        (blink_ph_nxt & bus.blink_mask[sel_nxt]);
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink_mask;
  assign suppress_nxt = bus.blank_mask[sel_nxt];
`endif

  // Scan FSM with registered sel/dec_en/frame_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      sel        <= 3'd0;
      dec_en     <= 1'b0;
      frame_done <= 1'b0;
    end else if (!bus.run) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      sel        <= 3'd0;
      dec_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          state  <= ST_DWELL;
          sel    <= 3'd0;
          cnt    <= 8'd0;
          dec_en <= ~suppress_nxt;
        end
        ST_DWELL: begin
          if (dwell_end) begin
            cnt <= 8'd0;
            if (GUARD > 0) begin
              state  <= ST_GUARD;
              dec_en <= 1'b0;
            end else begin
              sel        <= sel_inc;
              dec_en     <= ~suppress_nxt;
              frame_done <= wrap;
            end
          end else begin
            cnt    <= cnt + 8'd1;
            dec_en <= ~suppress_nxt;
          end
        end
        ST_GUARD: begin
          if (guard_end) begin
            state      <= ST_DWELL;
            sel        <= sel_inc;
            cnt        <= 8'd0;
            dec_en     <= ~suppress_nxt;
            frame_done <= wrap;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= 8'd0;
          sel    <= 3'd0;
          dec_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl. Instance a: DWELL=4, GUARD=2,
// BLINK_FRAMES=2 (48-cycle frame). Instance b: DWELL=1, GUARD=0 (8-cycle frame).
// Expected values come from closed-form timing of the scan pattern.
module tb_digit_scan_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  digit_scan_ctrl_if bus_a ();
  digit_scan_ctrl_if bus_b ();

  digit_scan_ctrl #(.DWELL(4), .GUARD(2), .BLINK_FRAMES(2)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  digit_scan_ctrl #(.DWELL(1), .GUARD(0), .BLINK_FRAMES(2)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Clock: 10 time units, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs of instance a, k cycles after the first DWELL cycle.
  task automatic chk_a(input string tag, input int k);
    int         d;
    int         f;
    logic       dark;
    logic [7:0] bl;
    logic [7:0] bk;
    d  = (k / 6) % 8;
    f  = k / 48;
    bl = bus_a.blank_mask;
    bk = bus_a.blink_mask;
`ifdef DIGIT_SCAN_BLINK_EN
    dark = (((f / 2) % 2) == 1) && bk[d];
`else
    dark = 1'b0;
`endif
    chk({tag, "_sel"}, 8'(bus_a.sel), 8'(d));
    chk({tag, "_en"}, 8'(bus_a.dec_en), 8'(((k % 6) < 4) && !bl[d] && !dark));
    chk({tag, "_fd"}, 8'(bus_a.frame_done), 8'((k > 0) && (k % 48 == 0)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a_sel"}, 8'(bus_a.sel), 8'd0);
    chk({tag, "_a_en"}, 8'(bus_a.dec_en), 8'd0);
    chk({tag, "_a_fd"}, 8'(bus_a.frame_done), 8'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus_a.run = 1'b0; bus_a.blank_mask = 8'h00; bus_a.blink_mask = 8'h00;
    bus_b.run = 1'b0; bus_b.blank_mask = 8'h00; bus_b.blink_mask = 8'h00;

    // Reset state
    step();
    step();
    chk_idle("rst");
    chk("rst_b_sel", 8'(bus_b.sel), 8'd0);
    chk("rst_b_en", 8'(bus_b.dec_en), 8'd0);
    reset = 1'b0;
    step();
    chk_idle("idle");

    // Free-running scan on both; blink_mask on digit 0 of instance a
    bus_a.blink_mask = 8'h01;
    bus_a.run = 1'b1;
    bus_b.run = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      step();
      chk_a("scan", k);
      chk("b_sel", 8'(bus_b.sel), 8'(k % 8));
      chk("b_en", 8'(bus_b.dec_en), 8'd1);
      chk("b_fd", 8'(bus_b.frame_done), 8'((k > 0) && (k % 8 == 0)));
    end

    // Stop both; next cycle must be idle
    bus_a.run = 1'b0;
    bus_b.run = 1'b0;
    step();
    chk_idle("stop");
    chk("stop_b_sel", 8'(bus_b.sel), 8'd0);
    chk("stop_b_en", 8'(bus_b.dec_en), 8'd0);

    // Restart with digit 2 blanked; drop run during DWELL of sel=5
    bus_a.blank_mask = 8'h04;
    bus_a.run = 1'b1;
    for (int k = 0; k <= 31; k++) begin
      step();
      chk_a("blank", k);
    end
    bus_a.run = 1'b0;
    step();
    chk_idle("drop5");

    // Re-raise run: restart at sel 0, no frame_done in first frame, blink
    // phase starts cleared
    bus_a.run = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      step();
      chk_a("rerun", k);
    end
    bus_a.run = 1'b0;
    step();
    chk_idle("stop2");

    // Asynchronous reset in the GUARD interval of sel=3
    bus_a.run = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      step();
      chk_a("pre_rst", k);
    end
    chk("guard_state", 8'(bus_a.dec_en), 8'd0);
    #3;
    reset = 1'b1;
    #1;
    chk_idle("async_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst_held");
    end
    reset = 1'b0;
    step();
    chk_a("post_rst", 0);
    step();
    chk_a("post_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
